// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcodes, branch codes, IR field positions and FSM states for the ID control unit
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_BNEQZ = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h10;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_BEQZ  = 2'b01;
    localparam logic [1:0] BR_BNEQZ = 2'b10;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS1_HI = 25;
    localparam int RS1_LO = 21;
    localparam int RS2_HI = 20;
    localparam int RS2_LO = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;

    typedef enum logic [1:0] {
        S_CLR   = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination shift register with RAW source compare
module hazard_scoreboard #(
    parameter int HAZ_DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_en,
    input  logic       load_valid,
    input  logic [4:0] load_rd,
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    output logic       stall,
    output logic       empty
);

    logic [HAZ_DEPTH-1:0] valid_q;
    logic [4:0]           rd_q [HAZ_DEPTH];

    // Advance one pipeline stage per cycle; entry 0 takes the instruction leaving ID
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) rd_q[i] <= '0;
        end else if (shift_en) begin
            valid_q[0] <= load_valid;
            rd_q[0]    <= load_rd;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                rd_q[i]    <= rd_q[i-1];
            end
        end
    end

    // Any used source naming a pending writer must wait; R0 is treated like any other register
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (valid_q[i] && ((rs1_used && (rs1 == rd_q[i])) || (rs2_used && (rs2 == rd_q[i]))))
                stall = 1'b1;
        end
    end

    assign empty = (valid_q == '0);

endmodule

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - ID-stage decode, RAW stall, branch flush and reset/halt sequencing
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int HAZ_DEPTH  = 3,
    parameter int CLR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_ID,
    input  logic        branch_taken_ex,
    output logic [5:0]  opcode,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        sel2,
    output logic        sel4,
    output logic        jump,
    output logic [1:0]  branch,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        clr_PC,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        halted,
    output logic        illegal
);

    localparam int CNT_W = 8;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               illegal_q;

    logic [5:0] ir_op;
    logic [4:0] ir_rs1, ir_rs2, ir_rd_r;
    logic       d_legal, d_hlt, d_rs1_used, d_rs2_used, d_writes, d_rtype;
    logic       d_sel2, d_sel4, d_jump, d_mem_rd, d_mem_wr;
    logic [1:0] d_branch;
    logic       sb_stall, sb_empty, sb_shift, sb_load;
    logic       go_drain, set_illegal;
    logic       unused_imm;

    assign ir_op      = IR_ID[OP_HI:OP_LO];
    assign ir_rs1     = IR_ID[RS1_HI:RS1_LO];
    assign ir_rs2     = IR_ID[RS2_HI:RS2_LO];
    assign ir_rd_r    = IR_ID[RD_HI:RD_LO];
    assign unused_imm = ^IR_ID[RD_LO-1:0];
    assign illegal    = illegal_q;

    // Static decode of the opcode into source usage, writeback and datapath selects
    always_comb begin
        d_legal    = 1'b1;
        d_hlt      = 1'b0;
        d_rs1_used = 1'b1;
        d_rs2_used = 1'b0;
        d_writes   = 1'b0;
        d_rtype    = 1'b0;
        d_sel2     = 1'b1;
        d_sel4     = 1'b1;
        d_jump     = 1'b0;
        d_mem_rd   = 1'b0;
        d_mem_wr   = 1'b0;
        d_branch   = BR_NONE;
        case (ir_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                d_rtype    = 1'b1;
                d_rs2_used = 1'b1;
                d_writes   = 1'b1;
                d_sel2     = 1'b0;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: d_writes = 1'b1;
            OP_LW: begin
                d_writes = 1'b1;
                d_mem_rd = 1'b1;
                d_sel4   = 1'b0;
            end
            OP_SW: begin
                d_rs2_used = 1'b1;
                d_mem_wr   = 1'b1;
            end
            OP_BEQZ:  d_branch = BR_BEQZ;
            OP_BNEQZ: d_branch = BR_BNEQZ;
            OP_J: begin
                d_rs1_used = 1'b0;
                d_jump     = 1'b1;
            end
            OP_HLT: begin
                d_hlt      = 1'b1;
                d_rs1_used = 1'b0;
            end
            default: begin
                d_legal    = 1'b0;
                d_rs1_used = 1'b0;
            end
        endcase
    end

    hazard_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (sb_shift),
        .load_valid (sb_load),
        .load_rd    (d_rtype ? ir_rd_r : ir_rs2),
        .rs1        (ir_rs1),
        .rs1_used   (d_rs1_used),
        .rs2        (ir_rs2),
        .rs2_used   (d_rs2_used),
        .stall      (sb_stall),
        .empty      (sb_empty)
    );

    // Per-cycle issue decision: flush beats stall beats HLT/issue; everything else is a bubble
    always_comb begin
        opcode      = 6'h00;
        rs1         = '0;
        rs2         = '0;
        rd          = '0;
        sel2        = 1'b0;
        sel4        = 1'b0;
        jump        = 1'b0;
        branch      = BR_NONE;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        clr_PC      = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        halted      = 1'b0;
        sb_shift    = 1'b0;
        sb_load     = 1'b0;
        go_drain    = 1'b0;
        set_illegal = 1'b0;
        if (reset || state == S_CLR) begin
            clr_PC = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    sb_shift = 1'b1;
                    if (branch_taken_ex) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (!sb_stall) begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        if (d_hlt) begin
                            go_drain = 1'b1;
                        end else if (!d_legal) begin
                            set_illegal = 1'b1;
                        end else begin
                            opcode  = ir_op;
                            rs1     = ir_rs1;
                            rs2     = ir_rs2;
                            rd      = d_rtype ? ir_rd_r : ir_rs2;
                            sel2    = d_sel2;
                            sel4    = d_sel4;
                            jump    = d_jump;
                            branch  = d_branch;
                            mem_rd  = d_mem_rd;
                            mem_wr  = d_mem_wr;
                            reg_wr  = d_writes;
                            sb_load = d_writes;
                        end
                    end
                end
                S_DRAIN: begin
                    sb_shift    = 1'b1;
                    if_id_flush = 1'b1;
                end
                S_HALT: begin
                    if_id_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: hold PC clear after reset, run, drain in-flight writers after HLT, then park
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLR;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (set_illegal) illegal_q <= 1'b1;
            case (state)
                S_CLR: begin
                    if (cnt == CNT_W'(CLR_CYCLES - 1)) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (go_drain) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (sb_empty && cnt >= CNT_W'(HAZ_DEPTH - 1)) state <= S_HALT;
                    else if (cnt < CNT_W'(HAZ_DEPTH - 1)) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed scoreboard bench for pipe_control_unit
module tb_pipe_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_ID = 32'd0;
    logic        branch_taken_ex = 1'b0;
    logic [5:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        sel2, sel4, jump, mem_rd, mem_wr, reg_wr;
    logic [1:0]  branch;
    logic        clr_PC, pc_en, if_id_en, if_id_flush, halted, illegal;

    pipe_control_unit #(.HAZ_DEPTH(3), .CLR_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .IR_ID           (IR_ID),
        .branch_taken_ex (branch_taken_ex),
        .opcode          (opcode),
        .rs1             (rs1),
        .rs2             (rs2),
        .rd              (rd),
        .sel2            (sel2),
        .sel4            (sel4),
        .jump            (jump),
        .branch          (branch),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .reg_wr          (reg_wr),
        .clr_PC          (clr_PC),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .halted          (halted),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    // {opcode, rd, pc_en, if_id_en, if_id_flush, reg_wr, mem_rd, mem_wr, jump, branch, clr_PC, halted, illegal}
    typedef logic [22:0] vec_t;

    vec_t exp_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    int   waited = 0;
    vec_t mon_exp, mon_act;
    int   mon_tag;

    function automatic vec_t ev(input logic [5:0] op, input logic [4:0] d, input logic pc,
                                input logic ie, input logic fl, input logic rw, input logic mr,
                                input logic mw, input logic j, input logic [1:0] br,
                                input logic clr, input logic hlt, input logic ill);
        return {op, d, pc, ie, fl, rw, mr, mw, j, br, clr, hlt, ill};
    endfunction

    function automatic vec_t e_bub(input logic pc, input logic ie, input logic fl,
                                   input logic clr, input logic hlt, input logic ill);
        return ev(6'h00, 5'd0, pc, ie, fl, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, clr, hlt, ill);
    endfunction

    function automatic vec_t e_iss(input logic [5:0] op, input logic [4:0] d, input logic rw,
                                   input logic mr, input logic mw, input logic [1:0] br);
        return ev(op, d, 1'b1, 1'b1, 1'b0, rw, mr, mw, 1'b0, br, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] rt(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d);
        return {op, s1, s2, d, 11'd0};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] d, input logic [15:0] imm);
        return {op, s1, d, imm};
    endfunction

    task automatic drive(input logic rst, input logic [31:0] ir, input logic bt,
                         input bit chk, input vec_t e);
        @(posedge clk);
        #1;
        reset           = rst;
        IR_ID           = ir;
        branch_taken_ex = bt;
        step_no++;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(step_no);
        end
    endtask

    assign mon_act = {opcode, rd, pc_en, if_id_en, if_id_flush, reg_wr, mem_rd, mem_wr,
                      jump, branch, clr_PC, halted, illegal};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL step %0d: got %h required %h", mon_tag, mon_act, mon_exp);
            end
        end
    end

    vec_t e_clr, e_stall, e_flush;

    initial begin
        e_clr   = e_bub(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_stall = e_bub(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_flush = e_bub(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset held three cycles, then two PC-clear cycles
        drive(1'b1, 32'd0, 1'b0, 1'b0, e_clr);
        drive(1'b1, 32'd0, 1'b0, 1'b1, e_clr);
        drive(1'b1, 32'd0, 1'b0, 1'b1, e_clr);
        #1;
        checks++;
        if ({clr_PC, pc_en, if_id_en, if_id_flush, halted, illegal} !== 6'b100000) begin
            errors++;
            $display("FAIL reset state: clr_PC=%b pc_en=%b if_id_en=%b if_id_flush=%b halted=%b illegal=%b",
                     clr_PC, pc_en, if_id_en, if_id_flush, halted, illegal);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1, e_clr);
        drive(1'b0, 32'd0, 1'b0, 1'b1, e_clr);

        // back-to-back RAW: three bubbles
        drive(1'b0, rt(6'h00, 5'd2, 5'd3, 5'd1), 1'b0, 1'b1, e_iss(6'h00, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 3; i++)
            drive(1'b0, rt(6'h00, 5'd1, 5'd5, 5'd4), 1'b0, 1'b1, e_stall);
        drive(1'b0, rt(6'h00, 5'd1, 5'd5, 5'd4), 1'b0, 1'b1, e_iss(6'h00, 5'd4, 1'b1, 1'b0, 1'b0, 2'b00));

        // load, three independent ops, store of the loaded register: no stall
        drive(1'b0, it(6'h08, 5'd0, 5'd6, 16'd4), 1'b0, 1'b1, e_iss(6'h08, 5'd6, 1'b1, 1'b1, 1'b0, 2'b00));
        drive(1'b0, it(6'h0A, 5'd8, 5'd7, 16'd1), 1'b0, 1'b1, e_iss(6'h0A, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00));
        drive(1'b0, rt(6'h01, 5'd10, 5'd11, 5'd9), 1'b0, 1'b1, e_iss(6'h01, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00));
        drive(1'b0, rt(6'h03, 5'd13, 5'd14, 5'd12), 1'b0, 1'b1, e_iss(6'h03, 5'd12, 1'b1, 1'b0, 1'b0, 2'b00));
        drive(1'b0, it(6'h09, 5'd0, 5'd6, 16'd0), 1'b0, 1'b1, e_iss(6'h09, 5'd6, 1'b0, 1'b0, 1'b1, 2'b00));

        // taken branch flushes; flushed op's rd is not tracked
        drive(1'b0, it(6'h0E, 5'd0, 5'd0, 16'd5), 1'b0, 1'b1, e_iss(6'h0E, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01));
        drive(1'b0, rt(6'h02, 5'd19, 5'd20, 5'd18), 1'b0, 1'b1, e_iss(6'h02, 5'd18, 1'b1, 1'b0, 1'b0, 2'b00));
        drive(1'b0, rt(6'h00, 5'd22, 5'd23, 5'd21), 1'b1, 1'b1, e_flush);
        drive(1'b0, rt(6'h00, 5'd21, 5'd22, 5'd24), 1'b0, 1'b1, e_iss(6'h00, 5'd24, 1'b1, 1'b0, 1'b0, 2'b00));

        // pending stall coinciding with a taken branch: flush wins, then stall resumes
        drive(1'b0, rt(6'h00, 5'd24, 5'd1, 5'd25), 1'b1, 1'b1, e_flush);
        drive(1'b0, rt(6'h00, 5'd24, 5'd1, 5'd25), 1'b0, 1'b1, e_stall);
        drive(1'b0, rt(6'h00, 5'd24, 5'd1, 5'd25), 1'b0, 1'b1, e_stall);
        drive(1'b0, rt(6'h00, 5'd24, 5'd1, 5'd25), 1'b0, 1'b1, e_iss(6'h00, 5'd25, 1'b1, 1'b0, 1'b0, 2'b00));

        // undefined opcode: bubble now, sticky flag from next cycle
        drive(1'b0, {6'h2A, 26'd0}, 1'b0, 1'b1, e_bub(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // HLT, three drain cycles, then parked in halt
        drive(1'b0, {6'h3F, 26'd0}, 1'b0, 1'b1, e_bub(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++)
            drive(1'b0, {6'h3F, 26'd0}, 1'b0, 1'b1, e_bub(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        drive(1'b0, {6'h2A, 26'd0}, 1'b1, 1'b1, e_bub(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
        #1;
        waited = 0;
        while (!halted && waited < 8) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL wait for halted expired after %0d cycles", waited);
        end
        drive(1'b0, rt(6'h00, 5'd2, 5'd3, 5'd1), 1'b0, 1'b1, e_bub(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));

        // reset clears halt and the sticky illegal flag
        drive(1'b1, 32'd0, 1'b0, 1'b0, e_clr);
        drive(1'b1, 32'd0, 1'b0, 1'b1, e_clr);
        drive(1'b0, 32'd0, 1'b0, 1'b1, e_clr);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
